// File: rtl/hex_scan_controller_if.sv
// Load channel between a requester and the hex scan controller.
// The requester offers a display word; the controller accepts it when load_ready is high.
interface hex_scan_controller_if;
    logic        load_valid;
    logic [15:0] load_data;
    logic [3:0]  load_blank;
    logic        load_ready;

    modport master (
        output load_valid,
        output load_data,
        output load_blank,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_blank,
        output load_ready
    );
endinterface

// File: rtl/hex_scan_controller.sv
// Four-digit multiplexed seven-segment scanner with a shared decoder and a double-buffered display word.
// New words are committed only at a frame boundary, so a frame never shows a mix of two words.
module hex_scan_controller #(
    parameter int unsigned DRIVE_CYCLES = 1000,
    parameter int unsigned DEAD_CYCLES  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    hex_scan_controller_if.slave    load,
    output logic [3:0]              dec_in,
    input  logic [6:0]              dec_out,
    output logic [6:0]              seg_out,
    output logic [3:0]              digit_sel,
    output logic                    frame_done
);

    localparam logic [15:0] DRIVE_LAST = 16'(DRIVE_CYCLES - 1);
    localparam logic [15:0] DEAD_LAST  = 16'(DEAD_CYCLES - 1);
    localparam logic [6:0]  SEG_OFF    = 7'h7F;

    typedef enum logic {
        DEAD,
        DRIVE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] active_data_q, active_data_d;
    logic [3:0]  active_blank_q, active_blank_d;
    logic [15:0] shadow_data_q, shadow_data_d;
    logic [3:0]  shadow_blank_q, shadow_blank_d;
    logic        pending_q, pending_d;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  sel_q, sel_d;
    logic        frame_done_q, frame_done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= DEAD;
            cnt_q          <= 16'd0;
            idx_q          <= 2'd0;
            active_data_q  <= 16'h0000;
            active_blank_q <= 4'hF;
            shadow_data_q  <= 16'h0000;
            shadow_blank_q <= 4'h0;
            pending_q      <= 1'b0;
            seg_q          <= SEG_OFF;
            sel_q          <= 4'b0000;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            active_data_q  <= active_data_d;
            active_blank_q <= active_blank_d;
            shadow_data_q  <= shadow_data_d;
            shadow_blank_q <= shadow_blank_d;
            pending_q      <= pending_d;
            seg_q          <= seg_d;
            sel_q          <= sel_d;
            frame_done_q   <= frame_done_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q + 16'd1;
        idx_d          = idx_q;
        active_data_d  = active_data_q;
        active_blank_d = active_blank_q;
        shadow_data_d  = shadow_data_q;
        shadow_blank_d = shadow_blank_q;
        pending_d      = pending_q;
        seg_d          = seg_q;
        sel_d          = sel_q;
        frame_done_d   = 1'b0;

        case (state_q)
            DEAD: begin
                // The decoder already sees the upcoming digit during DEAD, so its pattern is ready here.
                if (cnt_q == DEAD_LAST) begin
                    state_d = DRIVE;
                    cnt_d   = 16'd0;
                    if (active_blank_q[idx_q]) begin
                        seg_d = SEG_OFF;
                        sel_d = 4'b0000;
                    end else begin
                        seg_d = dec_out;
                        sel_d = 4'b0001 << idx_q;
                    end
                end
            end
            DRIVE: begin
                if (cnt_q == DRIVE_LAST) begin
                    state_d = DEAD;
                    cnt_d   = 16'd0;
                    idx_d   = idx_q + 2'd1;
                    seg_d   = SEG_OFF;
                    sel_d   = 4'b0000;
                    if (idx_q == 2'd3) begin
                        frame_done_d = 1'b1;
                        if (pending_q) begin
                            active_data_d  = shadow_data_q;
                            active_blank_d = shadow_blank_q;
                            pending_d      = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d = DEAD;
                cnt_d   = 16'd0;
            end
        endcase

        // Accept and commit are mutually exclusive: one needs pending clear, the other needs it set.
        if (load.load_valid && !pending_q) begin
            shadow_data_d  = load.load_data;
            shadow_blank_d = load.load_blank;
            pending_d      = 1'b1;
        end
    end

    always_comb begin
        dec_in = active_data_q[{idx_q, 2'b00} +: 4];
    end

    assign load.load_ready = ~pending_q;
    assign seg_out         = seg_q;
    assign digit_sel       = sel_q;
    assign frame_done      = frame_done_q;

endmodule

// File: doc/hex_scan_controller.md
HEX_SCAN_CONTROLLER -- requirements
Module: hex_scan_controller

Interface
REQ-001 Parameter DRIVE_CYCLES, default 1000, is the number of clocks each digit is lit (legal range 2..65535).
REQ-002 Parameter DEAD_CYCLES, default 8, is the number of all-off clocks before each digit (legal range 1..255).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-005 load_valid  input  1  requester offers a new display word.
REQ-006 load_data  input  16  four hex nibbles; nibble k (bits 4k+3:4k) is shown on digit k.
REQ-007 load_blank  input  4  bit k=1 forces digit k dark.
REQ-008 load_ready  output  1  equals NOT pending; a transfer occurs when load_valid and load_ready are both 1 on a clock edge.
REQ-009 dec_in  output  4  nibble presented to the shared seven-segment decoder; equals active nibble[idx], combinational from registers.
REQ-010 dec_out  input  7  the shared decoder's active-low segment pattern for dec_in (combinational return path).
REQ-011 seg_out  output  7  registered active-low segments to the panel; 7'h7F means all segments off.
REQ-012 digit_sel  output  4  registered one-hot, active-high digit enable; 4'b0000 means no digit lit.
REQ-013 frame_done  output  1  registered single-cycle pulse at the end of each 4-digit frame.

Function
REQ-014 The block has an FSM with states DEAD and DRIVE, a 2-bit digit index idx, and a 16-bit cycle counter cnt.
REQ-015 cnt restarts at 0 on entry to each state and increments each clock while in that state.
REQ-016 DEAD -> DRIVE transition occurs when cnt == DEAD_CYCLES-1, so DEAD lasts exactly DEAD_CYCLES clocks.
REQ-017 DRIVE -> DEAD transition occurs when cnt == DRIVE_CYCLES-1, so DRIVE lasts exactly DRIVE_CYCLES clocks.
REQ-018 On the DRIVE->DEAD edge, idx increments modulo 4 (3 wraps to 0).
REQ-019 During DEAD, digit_sel = 0 and seg_out = 7'h7F.
REQ-020 During DRIVE for an unblanked digit, digit_sel = one-hot(idx) and seg_out is registered from dec_out, with a 1-clock latency from dec_in.
REQ-021 During DRIVE for a blanked digit, digit_sel = 0 and seg_out = 7'h7F.
REQ-022 Output registers are loaded on the DEAD->DRIVE edge, so segments and enable change on the same clock.
REQ-023 Accepted data goes to shadow registers (shadow_data, shadow_blank) and sets pending; while pending = 1, load_valid is ignored.
REQ-024 Commit occurs on the DRIVE->DEAD edge when idx == 3 and pending == 1: active <= shadow and pending clears.
  - load_ready rises on the following clock.
  - The active word never changes mid-frame, so there is no tearing.
REQ-025 frame_done pulses high for exactly one clock after every DRIVE->DEAD edge with idx == 3, whether or not a commit occurred.
REQ-026 A load accepted on the same clock as a frame boundary with pending == 0 commits at the next frame boundary, not the current one.
REQ-027 Frame period is exactly 4*(DEAD_CYCLES+DRIVE_CYCLES) clocks.

Reset
REQ-028 When reset is asserted, the following apply immediately:
  - state = DEAD, idx = 0, cnt = 0;
  - active data = 16'h0000, active blank = 4'hF, shadow = 0, pending = 0;
  - seg_out = 7'h7F, digit_sel = 0, frame_done = 0, load_ready = 1.
REQ-029 Reset asserted mid-DRIVE darkens the panel without waiting for a clock.
REQ-030 After reset deasserts, scanning restarts at digit 0 with a full DEAD period, and all digits stay blank until the first commit.

Verification (DRIVE_CYCLES=4, DEAD_CYCLES=2, frame = 24 clocks)
REQ-031 Scenario: release reset, no loads -> digit_sel stays 0 and seg_out stays 7'h7F for 48 clocks; frame_done pulses at clocks 24 and 48.
REQ-032 Scenario: load 16'h4321 with blank 4'h0 before the first boundary -> in frame 2, digit_sel goes 0001/0010/0100/1000, each held 4 clocks after 2 dark clocks.
  - Required seg_out per digit: 7'h79, 7'h24, 7'h30, 7'h19.
REQ-033 Scenario: load 16'hDCBA with blank 4'b0100 -> digit 2 is dark, digit_sel = 0 in its slot; digits 0, 1, 3 show 7'h08, 7'h03, 7'h21.
REQ-034 Scenario: second load_valid while pending -> load_ready = 0 and the second word is dropped; the first word displays and load_ready returns to 1 one clock after commit.
REQ-035 Scenario: load accepted exactly on the boundary clock -> the old word shows for one more full frame, then the new word.
REQ-036 Scenario: assert reset mid-DRIVE of digit 2 -> seg_out = 7'h7F and digit_sel = 0 before the next clk edge.
  - After release, the first lit slot is digit 0, 2 clocks after scanning resumes, and it is blank until a reload.
